// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared fetch-path types and constants for the instruction queue.
// Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } ifq_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with push/pop/flush, head read from storage flops.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A push into a full FIFO is only taken when a pop frees a slot that cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Purpose  : Sequential fetch front end with in-order prefetch FIFO and redirect.
//            Define IFQ_BYPASS_EN for a zero-latency empty-queue response path.
// Revision : 1.0  initial release
// ============================================================================
module ifetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter logic [31:0] RESET_PC        = RESET_VECTOR,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req_valid,
  output logic [31:0]            mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_rsp_valid,
  input  logic [31:0]            mem_rsp_data,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  ifq_state_t       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] q_cnt;
  logic [31:0]      rsp_pc;
  fetch_entry_t     q_head;
  fetch_entry_t     q_push_entry;

  logic req_fire, rsp_fire, rsp_keep, rsp_drop;
  logic q_empty, q_push, q_pop, bypass;
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // The issued-address FIFO doubles as the outstanding-request counter.
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_fire),
    .flush     (1'b0),
    .head_data (rsp_pc),
    .count     (outstanding)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (q_push_entry),
    .pop       (q_pop),
    .flush     (redirect),
    .head_data (q_head),
    .count     (q_cnt)
  );

  // Gated by rst_n so no request is advertised while reset is held.
  always_comb begin
    mem_req_valid = rst_n
                 && (state_q == FETCH)
                 && (32'(outstanding) < MAX_OUTSTANDING)
                 && ((32'(q_cnt) + 32'(outstanding)) < DEPTH);
  end

  assign mem_req_addr = fetch_pc_q;
  assign req_fire     = mem_req_valid && mem_req_ready;
  assign rsp_fire     = mem_rsp_valid && (outstanding != '0);
  assign rsp_drop     = rsp_fire && (drop_cnt_q != '0);
  assign rsp_keep     = rsp_fire && (drop_cnt_q == '0);

  assign outstanding_nxt = outstanding + OUT_W'(req_fire) - OUT_W'(rsp_fire);

  assign q_empty = (q_cnt == '0);
  assign q_push_entry.pc    = rsp_pc;
  assign q_push_entry.instr = mem_rsp_data;

`ifdef IFQ_BYPASS_EN
  assign bypass = q_empty && (drop_cnt_q == '0) && !redirect && rsp_fire;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    out_valid = !q_empty || bypass;
    out_instr = bypass ? mem_rsp_data : q_head.instr;
    out_pc    = bypass ? rsp_pc       : q_head.pc;
    q_pop     = !q_empty && out_ready;
    q_push    = rsp_keep && !(bypass && out_ready);
    q_count   = q_cnt;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - OUT_W'(1);
    end
    // Every request still in flight after this edge belongs to the old stream.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_cnt_d = outstanding_nxt;
      state_d    = (outstanding_nxt != '0) ? DRAIN : FETCH;
    end else if ((state_q == DRAIN) && (drop_cnt_d == '0)) begin
      state_d = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_queue
// Purpose  : Directed vector bench for ifetch_queue with an in-order memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ifetch_queue;

  logic        clk;
  logic        rst_n;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  q_count;

  ifetch_queue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .q_count       (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-order memory: word at addr is ~addr, returned mem_lat cycles after acceptance.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          mem_lat = 1;
  int          ncyc    = 0;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (!rst_n) begin
      mq_addr.delete();
      mq_due.delete();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end else begin
      if ((mq_due.size() > 0) && (mq_due[0] <= ncyc)) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = ~mq_addr[0];
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
      if (mem_req_valid && mem_req_ready) begin
        mq_addr.push_back(mem_req_addr);
        mq_due.push_back(ncyc + mem_lat);
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] opc;
    logic [2:0]  q;
  } vec_t;

  vec_t t1[6];
  vec_t t2[25];

  int n_pass  = 0;
  int n_total = 0;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] addr,
                              input logic ov, input logic [31:0] opc, input logic [2:0] q);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.addr = addr; v.ov = ov; v.opc = opc; v.q = q;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat, input logic rdy);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = rdy;
    mem_lat     = lat;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    tick();
    out_ready = v.rdy;
    check({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'(v.rv));
    check({tag, " mem_req_addr"},  mem_req_addr, v.addr);
    check({tag, " out_valid"},     32'(out_valid), 32'(v.ov));
    check({tag, " q_count"},       32'(q_count), 32'(v.q));
    if (v.ov) begin
      check({tag, " out_pc"},    out_pc, v.opc);
      check({tag, " out_instr"}, out_instr, ~v.opc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;

    rst_n         = 1'b0;
    mem_req_ready = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    out_ready     = 1'b0;

    // Back-to-back fetch with a one-cycle memory and a consuming core.
    t1[0] = mk(1, 1, 32'h00, 0, 32'h0, 0);
    t1[1] = mk(1, 1, 32'h04, 0, 32'h0, 0);
    t1[2] = mk(1, 1, 32'h08, 1, 32'h0, 1);
    t1[3] = mk(1, 1, 32'h0C, 1, 32'h4, 1);
    t1[4] = mk(1, 1, 32'h10, 1, 32'h8, 1);
    t1[5] = mk(1, 1, 32'h14, 1, 32'hC, 1);

    // Stalled core: credits stop issue at DEPTH, then drain and resume at 0x10.
    t2[0] = mk(0, 1, 32'h00, 0, 32'h0, 0);
    t2[1] = mk(0, 1, 32'h04, 0, 32'h0, 0);
    t2[2] = mk(0, 1, 32'h08, 1, 32'h0, 1);
    t2[3] = mk(0, 1, 32'h0C, 1, 32'h0, 2);
    t2[4] = mk(0, 0, 32'h10, 1, 32'h0, 3);
    for (int i = 5; i < 20; i++) t2[i] = mk(0, 0, 32'h10, 1, 32'h0, 4);
    t2[20] = mk(1, 0, 32'h10, 1, 32'h00, 4);
    t2[21] = mk(1, 1, 32'h10, 1, 32'h04, 3);
    t2[22] = mk(1, 1, 32'h14, 1, 32'h08, 2);
    t2[23] = mk(1, 1, 32'h18, 1, 32'h0C, 2);
    t2[24] = mk(1, 1, 32'h1C, 1, 32'h10, 2);

    tick();
    check("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("reset out_valid",     32'(out_valid), 32'd0);
    check("reset out_instr",     out_instr, 32'd0);
    check("reset out_pc",        out_pc, 32'd0);
    check("reset q_count",       32'(q_count), 32'd0);

    do_reset(1, 1'b1);
    for (int i = 0; i < 6; i++) run_vec(t1[i], $sformatf("t1[%0d]", i));

    do_reset(1, 1'b0);
    for (int i = 0; i < 25; i++) run_vec(t2[i], $sformatf("t2[%0d]", i));

    // Redirect to an unaligned target with two requests in flight.
    do_reset(3, 1'b1);
    tick();
    tick();
    tick();
    check("t3 credit stall", 32'(mem_req_valid), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check("t3 drain no req", 32'(mem_req_valid), 32'd0);
    check("t3 drain out_valid", 32'(out_valid), 32'd0);
    tick();
    check("t3 drain2 no req", 32'(mem_req_valid), 32'd0);
    tick();
    check("t3 resume req_valid", 32'(mem_req_valid), 32'd1);
    check("t3 resume addr", mem_req_addr, 32'h0000_0100);
    seen = 1'b0;
    for (int i = 0; (i < 20) && !seen; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("t3 out_valid within bound", 32'(seen), 32'd1);
    if (seen) begin
      check("t3 first out_pc", out_pc, 32'h0000_0100);
      check("t3 first out_instr", out_instr, ~32'h0000_0100);
    end

    // Redirect coinciding with a pop and an arriving response.
    do_reset(1, 1'b1);
    repeat (4) tick();
    tick();
    check("t4 pre out_valid", 32'(out_valid), 32'd1);
    check("t4 pre out_pc", out_pc, 32'h8);
    check("t4 pre rsp_valid", 32'(mem_rsp_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("t4 flushed out_valid", 32'(out_valid), 32'd0);
    check("t4 flushed q_count", 32'(q_count), 32'd0);
    check("t4 drain no req", 32'(mem_req_valid), 32'd0);
    tick();
    check("t4 resume req_valid", 32'(mem_req_valid), 32'd1);
    check("t4 resume addr", mem_req_addr, 32'h0000_0200);
    check("t4 dropped rsp out_valid", 32'(out_valid), 32'd0);
    tick();
    check("t4 next addr", mem_req_addr, 32'h0000_0204);
    check("t4 still empty", 32'(out_valid), 32'd0);
    tick();
    check("t4 new out_valid", 32'(out_valid), 32'd1);
    check("t4 new out_pc", out_pc, 32'h0000_0200);
    check("t4 new q_count", 32'(q_count), 32'd1);

    // Address wrap at the top of the 32-bit space.
    do_reset(1, 1'b1);
    tick();
    check("t5 first addr", mem_req_addr, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("t5 drain no req", 32'(mem_req_valid), 32'd0);
    tick();
    check("t5 top addr", mem_req_addr, 32'hFFFF_FFFC);
    check("t5 top req_valid", 32'(mem_req_valid), 32'd1);
    tick();
    check("t5 wrapped addr", mem_req_addr, 32'h0000_0000);
    tick();
    check("t5 wrap out_valid", 32'(out_valid), 32'd1);
    check("t5 wrap out_pc", out_pc, 32'hFFFF_FFFC);
    check("t5 wrap out_instr", out_instr, 32'h0000_0003);

    // Asynchronous reset while draining stale responses.
    do_reset(3, 1'b1);
    tick();
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    tick();
    redirect = 1'b0;
    check("t6 in drain", 32'(mem_req_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 rst mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("t6 rst out_valid", 32'(out_valid), 32'd0);
    check("t6 rst out_instr", out_instr, 32'd0);
    check("t6 rst out_pc", out_pc, 32'd0);
    check("t6 rst q_count", 32'(q_count), 32'd0);
    mem_lat = 1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("t6 restart req_valid", 32'(mem_req_valid), 32'd1);
    check("t6 restart addr", mem_req_addr, 32'h0);
    tick();
    tick();
    check("t6 no drop out_valid", 32'(out_valid), 32'd1);
    check("t6 no drop out_pc", out_pc, 32'h0);
    check("t6 no drop out_instr", out_instr, ~32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle datapath's decode logic.
- Generates sequential word addresses and issues them to a pipelined instruction memory.
- Buffers returned instruction words in an in-order prefetch FIFO and hands them to the core over a valid/ready interface.
- Takes branch/jump redirects from the core, flushing the FIFO and discarding in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight requests (power of two, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- MAX_OUTSTANDING, 2, maximum issued-but-unreturned memory requests.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_addr  out  32  byte address, bits[1:0] always 0.
- mem_req_ready  in  1  memory accepts request this cycle.
- mem_rsp_valid  in  1  response word valid; responses return in request order, ≥1 cycle after acceptance.
- mem_rsp_data  in  32  instruction word.
- redirect  in  1  core requests a fetch restart.
- redirect_pc  in  32  new fetch address.
- out_valid  out  1  instruction available.
- out_ready  in  1  core consumes instruction (the core's ce).
- out_instr  out  32  instruction word.
- out_pc  out  32  address of out_instr.
- q_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; state=FETCH.
  - Outputs: mem_req_valid=0, out_valid=0, out_instr=0, out_pc=0, q_count=0.
- Credit rule: mem_req_valid=1 only when state==FETCH && outstanding<MAX_OUTSTANDING && (q_count+outstanding)<DEPTH. The FIFO therefore never overflows; an arriving response is always pushed.
- Request handshake: a request transfers on mem_req_valid&&mem_req_ready. fetch_pc+=4 and outstanding++ on that edge; fetch_pc wraps modulo 2^32. mem_req_addr=fetch_pc, and is held stable while valid and not ready.
- Each FIFO entry stores {pc, instr}. The pc is taken from a side FIFO of issued addresses (depth MAX_OUTSTANDING) popped on response.
- Response handling: a response decrements outstanding. With drop_cnt>0 it is discarded and drop_cnt--; otherwise it is pushed.
- Output:
  - out_valid = FIFO non-empty; out_instr/out_pc = head entry, registered, no combinational path from mem_rsp.
  - Pop on out_valid&&out_ready. Push and pop in the same cycle are both performed and q_count is unchanged.
  - Latency: response accepted at edge N → out_valid at edge N+1.
- Redirect (highest priority, takes effect on the edge where redirect=1):
  - FIFO cleared, including the entry being popped the same cycle; that pop still counts as consumed.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - drop_cnt = outstanding after the same-cycle request/response updates, so a response arriving that cycle is dropped, and a request accepted that cycle is counted.
  - state = DRAIN if that value >0, else FETCH.
  - out_valid=0 on the following cycle.
- State machine:
  - FETCH: issue per the credit rule; redirect → DRAIN or FETCH as above.
  - DRAIN: no requests issued; go to FETCH on the edge where drop_cnt reaches 0; a redirect in DRAIN reloads fetch_pc and drop_cnt.
- Spurious mem_rsp_valid with outstanding==0: ignored.

Optional Feature:
- IFQ_BYPASS_EN defined:
  - When FIFO empty, drop_cnt==0, no redirect and mem_rsp_valid=1, the response is driven combinationally on out_instr/out_pc with out_valid=1.
  - If out_ready=1 it is consumed without a push (zero latency); otherwise it is pushed normally.
- Undefined: strictly registered output, 1-cycle latency as above.

Decomposition:
- Shared package mips_pkg holds:
  - constants INSTR_W=32, PC_STEP=4, RESET_VECTOR;
  - typedef fetch_entry_t {pc[31:0], instr[31:0]};
  - enum ifq_state_t {FETCH, DRAIN}.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/flush, count). It is instantiated twice, for the instruction queue and the pc side FIFO.

Test Plan:
1. Reset, memory always ready, 1-cycle response, out_ready=1 → addresses 0x0,0x4,0x8… issued back-to-back; out_pc sequence 0x0,0x4,0x8 with matching instr; first out_valid 2 cycles after first request.
2. out_ready=0 for 20 cycles → exactly DEPTH=4 requests accepted, q_count=4, mem_req_valid=0; raise out_ready → 4 pops, fetching resumes at 0x10.
3. Memory latency 3 cycles, redirect to 0x103 with 2 outstanding → mem_req_addr=0x100 after DRAIN; the 2 stale words are never seen on out; first out_pc=0x100.
4. Redirect in the same cycle as a pop and a response → pop counted, FIFO empty next cycle, response dropped, out_valid=0.
5. fetch_pc=0xFFFF_FFFC → next request address 0x0000_0000.
6. rst_n asserted mid-DRAIN → all outputs 0 immediately; after release, fetch restarts at RESET_PC with drop_cnt=0.
